mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Multi-cycle multiply/divide engine in the EX stage, executing MIPS MULT, MULTU, DIV and DIVU. It drives the `mulalu` stall request into the pipeline hazard controller, which stalls IF/ID and ID/EX and flushes EX/MM until the result is ready. HI/LO results are held in registers for the downstream HI/LO writeback path.

Parameters:
- WIDTH, 32, operand width. Product and quotient/remainder width follows from it.
- MUL_LAT, 2, number of cycles `stall` is asserted for a multiply (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU; others are treated as NONE
- src_a  in  WIDTH  rs operand (multiplicand / dividend)
- src_b  in  WIDTH  rt operand (multiplier / divisor)
- hold  in  1  EX/MM stall from the controller; the instruction stays in EX
- flush  in  1  exception flush; aborts the operation in progress
- stall  out  1  to the controller `mulalu` input
- done  out  1  one-cycle-per-DONE-state result-valid flag
- hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, stall=0, all internal counters and shift registers cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- stall is combinational: (IDLE & op!=NONE & !flush) | MUL | DIV | FIX. It is low in DONE.
- Start cycle T, IDLE with op!=NONE:
  - Latch op and operands.
  - For signed ops, latch |src_a|, |src_b| and the sign flags.
  - Go to MUL (multiply) or DIV (divide) with count=0.
- Operands are sampled only at T. The controller holds EX stable while stall=1; later changes on src_a/src_b are ignored.
- MUL: stays MUL_LAT-1 cycles, then goes to DONE.
  - MUL_LAT=1 goes straight IDLE→DONE.
  - Multiply stall cycles = MUL_LAT.
  - Signed product is the full 2W-bit two's-complement result.
- DIV: restoring radix-2, one quotient bit per cycle, 32 cycles (count 0..31), then FIX.
  - FIX applies signs: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - FIX writes hi/lo, then goes to DONE.
  - Divide stall cycles = 1 (T) + 32 + 1 = 34; DONE at T+34.
- Divide by zero: no trap. The iteration still runs the full latency. Result: lo=all-ones, hi=src_a as latched (signed and unsigned).
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- DONE:
  - hi/lo are valid and done=1.
  - If hold=1, remain in DONE with stall=0 and no restart.
  - If hold=0, go to IDLE next cycle. The same instruction must not retrigger: IDLE accepts a new op only on the cycle after leaving DONE.
- hi/lo are updated only when a multiply reaches DONE or FIX completes; otherwise they hold their value.
- flush in any state:
  - Go to IDLE next cycle and clear done.
  - hi/lo are unchanged; a partial result is discarded.
  - flush overrides start in the same cycle: no operation is accepted.
- rst has priority over flush and everything else.

Decomposition:
- Shared package holds:
  - the op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state enum;
  - DIV_ITERS=32.
- One sub-module, `div_iter`: holds the remainder/quotient shift registers and performs one restoring step per enable. It is cleared on load.
- Multiply uses the inferred `*` operator with a MUL_LAT-deep register chain inside the top.

Test Plan:
- DIVU 100/7 at T → stall=1 for exactly 34 cycles; at T+34 done=1, lo=14, hi=2, stall=0. The next cycle is IDLE.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- MULT 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE after 2 stall cycles. MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIVU 5/0 → after 34 cycles, lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIVU; assert flush at T+10 → IDLE at T+11, stall=0, hi/lo keep the prior values. A fresh op with flush high in the same cycle is not accepted.
- MULTU completes while hold=1 for 3 cycles → stays DONE, stall=0, done=1 throughout, no second start. When hold drops → IDLE, with a single result write.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine: operation codes,
// controller state encoding and the divider iteration count.
package mul_div_unit_pkg;

   // Operation codes presented on the op port by the decoder
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;

   // Controller state enumeration
   typedef logic [2:0] md_state_t;
   localparam md_state_t ST_IDLE = 3'd0;
   localparam md_state_t ST_MUL  = 3'd1;
   localparam md_state_t ST_DIV  = 3'd2;
   localparam md_state_t ST_FIX  = 3'd3;
   localparam md_state_t ST_DONE = 3'd4;

   // One quotient bit is produced per divide iteration
   localparam int DIV_ITERS = 32;

   // Codes 5..7 are not instructions and behave like MD_NONE
   function automatic logic op_is_valid(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Restoring radix-2 divider datapath: holds the partial remainder, the
// dividend/quotient shift register and the divisor. One step per enable.
module mul_div_unit_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;

   // One restoring step: shift in the next dividend bit, trial-subtract the divisor
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs_q};
      rem_d     = rem_shift[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_d = diff[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   // Datapath registers: cleared on reset and on load, stepped on enable
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
      end else if (en_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU engine. Drives the pipeline
// stall request while busy and holds the HI/LO results for writeback.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hold,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Product chain depth: the hi/lo registers form the last multiply stage
   localparam int         PIPE_N   = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
   localparam logic [5:0] MUL_LAST = 6'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
   localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

   md_state_t          state_q, state_d;
   logic [5:0]         count_q, count_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               quo_neg_q, rem_neg_q, dbz_q;
   logic [2*WIDTH-1:0] mul_pipe_q [PIPE_N];

   logic               accept;
   logic               a_neg_c, b_neg_c;
   logic [WIDTH-1:0]   a_mag_c, b_mag_c;
   logic [2*WIDTH-1:0] mag_prod_c, mul_prod_c, mul_res_c;
   logic               div_load, div_en;
   logic [WIDTH-1:0]   div_quo, div_rem;

   // A new operation is taken only from IDLE, and never alongside a flush
   assign accept = (state_q == ST_IDLE) && op_is_valid(op) && !flush;

   // Operand magnitudes and the full-width signed/unsigned product at the start cycle
   always_comb begin
      a_neg_c    = op_is_signed(op) && src_a[WIDTH-1];
      b_neg_c    = op_is_signed(op) && src_b[WIDTH-1];
      a_mag_c    = a_neg_c ? -src_a : src_a;
      b_mag_c    = b_neg_c ? -src_b : src_b;
      mag_prod_c = {{WIDTH{1'b0}}, a_mag_c} * {{WIDTH{1'b0}}, b_mag_c};
      mul_prod_c = (a_neg_c ^ b_neg_c) ? -mag_prod_c : mag_prod_c;
      mul_res_c  = (MUL_LAT == 1) ? mul_prod_c : mul_pipe_q[PIPE_N-1];
   end

   mul_div_unit_div_iter #(
      .WIDTH (WIDTH)
   ) div_iter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (div_load),
      .en_i       (div_en),
      .dividend_i (a_mag_c),
      .divisor_i  (b_mag_c),
      .quo_o      (div_quo),
      .rem_o      (div_rem)
   );

   // Controller next-state and result write selection; flush overrides everything below reset
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      div_load = 1'b0;
      div_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               count_d = '0;
               if (op_is_div(op)) begin
                  state_d  = ST_DIV;
                  div_load = 1'b1;
               end else if (MUL_LAT == 1) begin
                  state_d       = ST_DONE;
                  {hi_d, lo_d}  = mul_prod_c;
               end else begin
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL: begin
            if (count_q == MUL_LAST) begin
               state_d      = ST_DONE;
               {hi_d, lo_d} = mul_res_c;
            end else begin
               count_d = count_q + 6'd1;
            end
         end
         ST_DIV: begin
            div_en = 1'b1;
            if (count_q == DIV_LAST) begin
               state_d = ST_FIX;
            end else begin
               count_d = count_q + 6'd1;
            end
         end
         ST_FIX: begin
            // Divide by zero leaves the dividend magnitude in the remainder,
            // so the dividend sign rule alone restores hi to the original src_a
            hi_d    = rem_neg_q ? -div_rem : div_rem;
            lo_d    = dbz_q ? '1 : (quo_neg_q ? -div_quo : div_quo);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!hold) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d  = ST_IDLE;
         count_d  = '0;
         hi_d     = hi_q;
         lo_d     = lo_q;
         div_load = 1'b0;
         div_en   = 1'b0;
      end
   end

   // Controller state, result registers and start-cycle sign flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         if (accept) begin
            quo_neg_q <= a_neg_c ^ b_neg_c;
            rem_neg_q <= a_neg_c;
            dbz_q     <= (src_b == '0);
         end
      end
   end

   // Product register chain: loaded at the start cycle, then shifted one stage per cycle
   // NOTE: this array is a handful of flops, not a RAM, so it is reset like any other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_N; i++) mul_pipe_q[i] <= '0;
      end else begin
         if (accept) mul_pipe_q[0] <= mul_prod_c;
         for (int i = 1; i < PIPE_N; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
   end

   assign stall = accept || (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
   assign done  = (state_q == ST_DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 2;
   localparam int DIV_STALL = 34;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a, src_b;
   logic             hold, flush;
   logic             stall, done;
   logic [WIDTH-1:0] hi, lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_hi  = '0;
   logic [31:0] last_lo  = '0;

   always #5 clk = ~clk;

   mul_div_unit #(
      .WIDTH   (WIDTH),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hold  (hold),
      .flush (flush),
      .stall (stall),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: MIPS HI/LO results from plain integer arithmetic
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa, sb, q, r;
      logic [31:0] qq, rr;
      ref_result = '0;
      case (o)
         MD_MULT: begin
            sa = a; sb = b;
            sp = longint'(sa) * longint'(sb);
            ref_result = sp;
         end
         MD_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            ref_result = up;
         end
         MD_DIV: begin
            if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = {32'd0, 32'h8000_0000};
            else begin
               sa = a; sb = b;
               q = sa / sb; r = sa % sb;
               qq = q; rr = r;
               ref_result = {rr, qq};
            end
         end
         MD_DIVU: begin
            if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
            else ref_result = {a % b, a / b};
         end
         default: ref_result = '0;
      endcase
   endfunction

   // Issue one instruction, count its stall cycles, check the DONE result,
   // optionally keep it in EX with hold, then let it retire
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold_cycles, input string tag);
      logic [63:0] exp;
      int          exp_stall;
      int          cnt;
      exp       = ref_result(o, a, b);
      exp_stall = op_is_div(o) ? DIV_STALL : MUL_LAT;
      @(negedge clk);
      op = o; src_a = a; src_b = b;
      #1;
      cnt = 0;
      while (stall === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
         src_a = $urandom; src_b = $urandom;
         #1;
      end
      check({tag, " stall_cycles"}, cnt, exp_stall);
      check({tag, " done"}, {31'd0, done}, 32'd1);
      check({tag, " hi"}, hi, exp[63:32]);
      check({tag, " lo"}, lo, exp[31:0]);
      if (hold_cycles > 0) begin
         hold = 1'b1;
         for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            #1;
            check({tag, " hold_done"}, {31'd0, done}, 32'd1);
            check({tag, " hold_stall"}, {31'd0, stall}, 32'd0);
            check({tag, " hold_hi"}, hi, exp[63:32]);
            check({tag, " hold_lo"}, lo, exp[31:0]);
         end
         hold = 1'b0;
      end
      op = MD_NONE;
      @(negedge clk);
      #1;
      check({tag, " idle_done"}, {31'd0, done}, 32'd0);
      check({tag, " idle_stall"}, {31'd0, stall}, 32'd0);
      check({tag, " idle_hi"}, hi, exp[63:32]);
      check({tag, " idle_lo"}, lo, exp[31:0]);
      last_hi = exp[63:32];
      last_lo = exp[31:0];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;

      rst = 1'b1; op = MD_NONE; src_a = '0; src_b = '0; hold = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset stall", {31'd0, stall}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      rst = 1'b0;

      // Directed corner cases
      run_op(MD_DIVU, 32'd100, 32'd7, 0, "divu_100_7");
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
      run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 0, "mult_m1_2");
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu_ff_2");
      run_op(MD_DIVU, 32'd5, 32'd0, 0, "divu_by_zero");
      run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, 0, "div_neg_by_zero");
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");

      // Flush mid-divide: partial result dropped, hi/lo untouched
      @(negedge clk);
      op = MD_DIVU; src_a = 32'd1000; src_b = 32'd3;
      #1;
      check("flush start_stall", {31'd0, stall}, 32'd1);
      repeat (10) @(negedge clk);
      #1;
      check("flush busy_stall", {31'd0, stall}, 32'd1);
      flush = 1'b1; op = MD_NONE;
      @(negedge clk);
      #1;
      check("flush idle_stall", {31'd0, stall}, 32'd0);
      check("flush idle_done", {31'd0, done}, 32'd0);
      check("flush keep_hi", hi, last_hi);
      check("flush keep_lo", lo, last_lo);
      // A new op presented together with flush is not accepted
      op = MD_DIVU; src_a = 32'd9; src_b = 32'd2;
      #1;
      check("flush start_blocked_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      flush = 1'b0; op = MD_NONE;
      #1;
      check("flush no_accept_stall", {31'd0, stall}, 32'd0);
      check("flush no_accept_done", {31'd0, done}, 32'd0);
      check("flush no_accept_lo", lo, last_lo);

      // Result held in EX by the controller
      run_op(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 3, "multu_hold");

      // Undefined op codes are ignored
      @(negedge clk);
      op = 3'd5; src_a = 32'd3; src_b = 32'd4;
      #1;
      check("bad_op stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      op = MD_NONE;
      #1;
      check("bad_op stall_after", {31'd0, stall}, 32'd0);
      check("bad_op done_after", {31'd0, done}, 32'd0);
      check("bad_op lo_after", lo, last_lo);

      // Random operations
      for (int n = 0; n < 24; n++) begin
         r_op = 3'($urandom_range(1, 4));
         r_a  = $urandom;
         case ($urandom_range(0, 4))
            0:       r_b = 32'd0;
            1:       r_b = $urandom_range(1, 15);
            2:       r_b = -$urandom_range(1, 15);
            3:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            default: r_b = $urandom;
         endcase
         run_op(r_op, r_a, r_b, $urandom_range(0, 2), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
